mcht_rx_dec: RTL and testbench

Standalone Manchester receive decoder for the MCHT link: it recovers `pRX_MSG_LEN`-bit frames from the serial line at 4x oversampling on the 100 MHz domain. It is the receive end paired with the MCHT transmit path and is checked by feeding it the transmit output in internal loopback, where it serves as the BIST frame checker. It presents the last good message plus one-cycle valid and error pulses, and it keeps a saturating error count.

---
 rtl/mcht_pkg.sv | 17 +
 rtl/mcht_sync.sv | 30 +++
 rtl/mcht_rx_dec.sv | 145 ++++++++++++++
 tb/tb_mcht_rx_dec.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcht_pkg.sv
// mcht_pkg: shared types and constants for the MCHT Manchester link.
// Holds the receive FSM state enum, oversampling ratio and sample phases.
package mcht_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    STOP,
    HUNT
  } mcht_rx_st_e;

  localparam int         MCHT_OVS  = 4;
  localparam logic [1:0] MCHT_PH_A = 2'd1;
  localparam logic [1:0] MCHT_PH_B = 2'd3;

endpackage

// File: rtl/mcht_sync.sv
// mcht_sync: 2-FF synchronizer plus previous-value flop for the RX line.
// Ports: clk, rst (sync, active high), rxd in; rxd_s, fall out.
module mcht_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic s1;
  logic rxd_p;

  // Reset to the idle-high level so leaving reset never
  // looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      s1    <= rxd;
      rxd_s <= s1;
      rxd_p <= rxd_s;
    end
  end

  assign fall = ~rxd_s & rxd_p;

endmodule

// File: rtl/mcht_rx_dec.sv
// mcht_rx_dec: Manchester frame receiver, 4x oversampled, MSB first.
// Ports: CLK100M, RST, RXD, EN in; RX_MSG, RX_VLD, RX_ERR, RX_BSY, ERR_CNT out.
module mcht_rx_dec
  import mcht_pkg::*;
#(
  parameter int pRX_MSG_LEN = 8,
  parameter int pIDLE_BITS  = 2
) (
  input  logic                   CLK100M,
  input  logic                   RST,
  input  logic                   RXD,
  input  logic                   EN,
  output logic [pRX_MSG_LEN-1:0] RX_MSG,
  output logic                   RX_VLD,
  output logic                   RX_ERR,
  output logic                   RX_BSY,
  output logic [7:0]             ERR_CNT
);

  localparam int BW = (pRX_MSG_LEN > 1) ? $clog2(pRX_MSG_LEN) : 1;
  localparam int HN = MCHT_OVS * pIDLE_BITS;
  localparam int HW = $clog2(HN + 1);

  logic rxd_s;
  logic fall;

  mcht_sync u_sync (
    .clk   (CLK100M),
    .rst   (RST),
    .rxd   (RXD),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  mcht_rx_st_e            st, st_n;
  logic [1:0]             ph, ph_n;
  logic                   a, a_n;
  logic [BW-1:0]          cnt, cnt_n;
  logic [pRX_MSG_LEN-1:0] sh, sh_n;
  logic [HW-1:0]          hcnt, hcnt_n;
  logic [pRX_MSG_LEN-1:0] msg_n;
  logic                   vld_n;
  logic                   err_n;
  logic [7:0]             ecnt_n;

  always_ff @(posedge CLK100M) begin
    if (RST) begin
      st      <= IDLE;
      ph      <= '0;
      a       <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      hcnt    <= '0;
      RX_MSG  <= '0;
      RX_VLD  <= 1'b0;
      RX_ERR  <= 1'b0;
      RX_BSY  <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      st      <= st_n;
      ph      <= ph_n;
      a       <= a_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      hcnt    <= hcnt_n;
      RX_MSG  <= msg_n;
      RX_VLD  <= vld_n;
      RX_ERR  <= err_n;
      RX_BSY  <= (st_n != IDLE);
      ERR_CNT <= ecnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    ph_n   = ph + 2'd1;
    a_n    = a;
    cnt_n  = cnt;
    sh_n   = sh;
    hcnt_n = '0;
    msg_n  = RX_MSG;
    vld_n  = 1'b0;
    err_n  = 1'b0;

    if (ph == MCHT_PH_A) a_n = rxd_s;

    unique case (st)
      IDLE: begin
        // The edge cycle itself is phase 0 of SOF.
        ph_n = 2'd1;
        if (fall) st_n = SOF;
      end
      SOF: begin
        cnt_n = '0;
        if (ph == MCHT_PH_B) begin
          if (!a && rxd_s) st_n = DATA;
          else             st_n = IDLE;
        end
      end
      DATA: begin
        if (ph == MCHT_PH_B) begin
          if (a == rxd_s) begin
            err_n = 1'b1;
            st_n  = HUNT;
          end else begin
            sh_n  = (sh << 1) | pRX_MSG_LEN'(rxd_s);
            cnt_n = cnt + 1'b1;
            if (cnt == BW'(pRX_MSG_LEN - 1)) st_n = STOP;
          end
        end
      end
      STOP: begin
        if (ph == MCHT_PH_B) begin
          if (a && rxd_s) begin
            msg_n = sh;
            vld_n = 1'b1;
            st_n  = IDLE;
          end else begin
            err_n = 1'b1;
            st_n  = HUNT;
          end
        end
      end
      HUNT: begin
        if (rxd_s) begin
          if (hcnt == HW'(HN - 1)) st_n = IDLE;
          else                     hcnt_n = hcnt + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase

    // Disable aborts any frame without reporting it.
    if (!EN) begin
      st_n  = IDLE;
      msg_n = RX_MSG;
      vld_n = 1'b0;
      err_n = 1'b0;
    end

    ecnt_n = ERR_CNT;
    if (err_n && ERR_CNT != 8'hFF) ecnt_n = ERR_CNT + 8'd1;
  end

endmodule

// File: tb/tb_mcht_rx_dec.sv
// tb_mcht_rx_dec: directed bench for the Manchester receive decoder.
// Drives hand-built frames and checks pulses, timing and counters.
module tb_mcht_rx_dec;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       en;
  logic [7:0] rx_msg;
  logic       rx_vld;
  logic       rx_err;
  logic       rx_bsy;
  logic [7:0] err_cnt;

  int tests;
  int fails;
  int cyc;
  int vld_cnt;
  int err_cnt_mon;
  int both_cnt;
  int last_vld;
  int prev_vld;
  int last_err;

  mcht_rx_dec #(
    .pRX_MSG_LEN (8),
    .pIDLE_BITS  (2)
  ) dut (
    .CLK100M (clk),
    .RST     (rst),
    .RXD     (rxd),
    .EN      (en),
    .RX_MSG  (rx_msg),
    .RX_VLD  (rx_vld),
    .RX_ERR  (rx_err),
    .RX_BSY  (rx_bsy),
    .ERR_CNT (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_vld) begin
      vld_cnt  = vld_cnt + 1;
      prev_vld = last_vld;
      last_vld = cyc;
    end
    if (rx_err) begin
      err_cnt_mon = err_cnt_mon + 1;
      last_err    = cyc;
    end
    if (rx_vld && rx_err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sym(input logic v);
    if (v) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end else begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
  endtask

  task automatic frame(input logic [7:0] m, output int t0);
    t0 = cyc;
    sym(1'b1);
    for (int i = 7; i >= 0; i--) sym(m[i]);
    hold(1'b1, 4);
  endtask

  // SOF then a flat-high bit 0: one code violation, then re-arm.
  task automatic bad();
    hold(1'b0, 2);
    hold(1'b1, 18);
  endtask

  int t0, t1, t2;
  int v0, e0;
  logic [7:0] m;

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    vld_cnt     = 0;
    err_cnt_mon = 0;
    both_cnt    = 0;
    last_vld    = 0;
    prev_vld    = 0;
    last_err    = 0;
    rst         = 1'b1;
    en          = 1'b1;
    rxd         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_msg", 32'(rx_msg), 32'h00);
    check("rst_vld", 32'(rx_vld), 32'h0);
    check("rst_err", 32'(rx_err), 32'h0);
    check("rst_bsy", 32'(rx_bsy), 32'h0);
    check("rst_cnt", 32'(err_cnt), 32'h00);
    rst = 1'b0;
    hold(1'b1, 10);

    // good frame, VLD 42 cycles after the first low
    v0 = vld_cnt; e0 = err_cnt_mon;
    frame(8'hA5, t0);
    hold(1'b1, 4);
    check("a5_nvld", 32'(vld_cnt - v0), 32'd1);
    check("a5_time", 32'(last_vld - t0), 32'd42);
    check("a5_msg", 32'(rx_msg), 32'hA5);
    check("a5_cnt", 32'(err_cnt), 32'd0);
    check("a5_nerr", 32'(err_cnt_mon - e0), 32'd0);

    // abutting frames: pulses one frame (40 cycles) apart
    v0 = vld_cnt;
    frame(8'h00, t1);
    frame(8'hFF, t2);
    hold(1'b1, 4);
    check("b2b_nvld", 32'(vld_cnt - v0), 32'd2);
    check("b2b_gap", 32'(last_vld - prev_vld), 32'd40);
    check("b2b_time", 32'(last_vld - t2), 32'd42);
    check("b2b_msg", 32'(rx_msg), 32'hFF);

    // data bit 3 flat high
    v0 = vld_cnt; e0 = err_cnt_mon;
    m = 8'hA5;
    t0 = cyc;
    sym(1'b1);
    for (int i = 7; i >= 5; i--) sym(m[i]);
    hold(1'b1, 4);
    hold(1'b1, 16);
    check("cv_nerr", 32'(err_cnt_mon - e0), 32'd1);
    check("cv_time", 32'(last_err - t0), 32'd22);
    check("cv_nvld", 32'(vld_cnt - v0), 32'd0);
    check("cv_cnt", 32'(err_cnt), 32'd1);
    check("cv_msg", 32'(rx_msg), 32'hFF);
    frame(8'h3C, t0);
    hold(1'b1, 4);
    check("rearm_nvld", 32'(vld_cnt - v0), 32'd1);
    check("rearm_msg", 32'(rx_msg), 32'h3C);

    // STOP period low
    v0 = vld_cnt; e0 = err_cnt_mon;
    m = 8'h5A;
    t0 = cyc;
    sym(1'b1);
    for (int i = 7; i >= 0; i--) sym(m[i]);
    hold(1'b0, 4);
    hold(1'b1, 16);
    check("stop_nerr", 32'(err_cnt_mon - e0), 32'd1);
    check("stop_time", 32'(last_err - t0), 32'd42);
    check("stop_nvld", 32'(vld_cnt - v0), 32'd0);
    check("stop_cnt", 32'(err_cnt), 32'd2);
    check("stop_msg", 32'(rx_msg), 32'h3C);

    // 1-cycle glitch on idle line
    v0 = vld_cnt; e0 = err_cnt_mon;
    hold(1'b0, 1);
    hold(1'b1, 5);
    check("gl_bsy", 32'(rx_bsy), 32'h0);
    hold(1'b1, 8);
    check("gl_nvld", 32'(vld_cnt - v0), 32'd0);
    check("gl_nerr", 32'(err_cnt_mon - e0), 32'd0);

    // EN dropped at bit 4
    v0 = vld_cnt; e0 = err_cnt_mon;
    m = 8'hC3;
    sym(1'b1);
    for (int i = 7; i >= 4; i--) sym(m[i]);
    en = 1'b0;
    hold(rxd, 1);
    check("en_bsy", 32'(rx_bsy), 32'h0);
    for (int i = 3; i >= 0; i--) sym(m[i]);
    hold(1'b1, 8);
    en = 1'b1;
    hold(1'b1, 4);
    check("en_nvld", 32'(vld_cnt - v0), 32'd0);
    check("en_nerr", 32'(err_cnt_mon - e0), 32'd0);
    check("en_msg", 32'(rx_msg), 32'h3C);
    check("en_cnt", 32'(err_cnt), 32'd2);

    // RST at bit 4
    v0 = vld_cnt; e0 = err_cnt_mon;
    sym(1'b1);
    for (int i = 7; i >= 4; i--) sym(m[i]);
    rst = 1'b1;
    hold(1'b1, 1);
    rst = 1'b0;
    check("mr_msg", 32'(rx_msg), 32'h00);
    check("mr_cnt", 32'(err_cnt), 32'd0);
    check("mr_bsy", 32'(rx_bsy), 32'h0);
    check("mr_vld", 32'(rx_vld), 32'h0);
    check("mr_err", 32'(rx_err), 32'h0);
    hold(1'b1, 20);
    check("mr_nvld", 32'(vld_cnt - v0), 32'd0);
    check("mr_nerr", 32'(err_cnt_mon - e0), 32'd0);

    // error counter saturation
    e0 = err_cnt_mon;
    for (int i = 0; i < 254; i++) bad();
    check("sat_254", 32'(err_cnt), 32'd254);
    bad();
    check("sat_255", 32'(err_cnt), 32'd255);
    e0 = err_cnt_mon;
    for (int i = 0; i < 5; i++) bad();
    check("sat_hold", 32'(err_cnt), 32'd255);
    check("sat_pulse", 32'(err_cnt_mon - e0), 32'd5);
    check("sat_msg", 32'(rx_msg), 32'h00);

    check("vld_err_excl", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
